// File: rtl/pipeline_control_unit_pkg.sv
// pipeline_control_unit_pkg: shared state encodings and constants for the pipeline sequencer
package pipeline_control_unit_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_EXEC = 3'd3,
        HALTED    = 3'd4
    } state_t;

    localparam int DRAIN_CYCLES_DEFAULT = 3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// pipeline_control_unit_if: hazard/step inputs and stage enable/flush outputs of the sequencer
interface pipeline_control_unit_if #(
    parameter int NB_ADDR = 5
);
    logic               i_start;
    logic               i_mode_step;
    logic               i_step;
    logic               i_halt_detected;
    logic               i_id_ex_mem_rd_enb;
    logic [NB_ADDR-1:0] i_id_ex_rt_addr;
    logic [NB_ADDR-1:0] i_if_id_rs_addr;
    logic [NB_ADDR-1:0] i_if_id_rt_addr;
    logic               i_branch_taken;
    logic               o_pc_enb;
    logic               o_if_id_enb;
    logic               o_if_id_flush;
    logic               o_id_ex_flush;
    logic               o_pipe_enb;
    logic               o_step_done;
    logic               o_halted;
    logic [2:0]         o_state;

    modport master (
        input  i_start, i_mode_step, i_step, i_halt_detected, i_id_ex_mem_rd_enb,
               i_id_ex_rt_addr, i_if_id_rs_addr, i_if_id_rt_addr, i_branch_taken,
        output o_pc_enb, o_if_id_enb, o_if_id_flush, o_id_ex_flush, o_pipe_enb,
               o_step_done, o_halted, o_state
    );

    modport slave (
        output i_start, i_mode_step, i_step, i_halt_detected, i_id_ex_mem_rd_enb,
               i_id_ex_rt_addr, i_if_id_rs_addr, i_if_id_rt_addr, i_branch_taken,
        input  o_pc_enb, o_if_id_enb, o_if_id_flush, o_id_ex_flush, o_pipe_enb,
               o_step_done, o_halted, o_state
    );
endinterface

// File: rtl/pipeline_control_unit_hazard_detection_unit.sv
// pipeline_control_unit_hazard_detection_unit: flags a load in ID/EX feeding the instruction in IF/ID
module pipeline_control_unit_hazard_detection_unit #(
    parameter int NB_ADDR = 5
)(
    input  logic               i_id_ex_mem_rd_enb,
    input  logic [NB_ADDR-1:0] i_id_ex_rt_addr,
    input  logic [NB_ADDR-1:0] i_if_id_rs_addr,
    input  logic [NB_ADDR-1:0] i_if_id_rt_addr,
    output logic               o_luh
);
    // Register 0 is hardwired, so a load into it never creates a dependency
    always_comb o_luh = i_id_ex_mem_rd_enb && (i_id_ex_rt_addr != '0) &&
                        ((i_id_ex_rt_addr == i_if_id_rs_addr) || (i_id_ex_rt_addr == i_if_id_rt_addr));
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: five-stage pipeline sequencer with step mode, load-use stall, branch squash and HALT drain
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int NB_ADDR      = 5,
    parameter int NB_DRAIN     = 2,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
)(
    input logic                     i_clock,
    input logic                     i_reset,
    pipeline_control_unit_if.master bus
);
    state_t              state, state_next;
    logic                draining, step_q, step_done, halted;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                luh, adv, stall, step_rise, halt_start, halt_now;

    pipeline_control_unit_hazard_detection_unit #(.NB_ADDR(NB_ADDR)) u_hdu (
        .i_id_ex_mem_rd_enb (bus.i_id_ex_mem_rd_enb),
        .i_id_ex_rt_addr    (bus.i_id_ex_rt_addr),
        .i_if_id_rs_addr    (bus.i_if_id_rs_addr),
        .i_if_id_rt_addr    (bus.i_if_id_rt_addr),
        .o_luh              (luh)
    );

    // Advance qualifier, stall cause and drain events; a held i_step only counts once via its rising edge
    always_comb begin
        adv        = (state == RUN) || (state == STEP_EXEC);
        stall      = draining || bus.i_halt_detected || luh;
        step_rise  = bus.i_step && !step_q;
        halt_start = adv && bus.i_halt_detected && !bus.i_branch_taken && !draining;
        halt_now   = adv && draining && (drain_cnt == '0);
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = bus.i_start ? (bus.i_mode_step ? STEP_WAIT : RUN) : IDLE;
            RUN:       state_next = halt_now ? HALTED : RUN;
            STEP_WAIT: state_next = step_rise ? STEP_EXEC : STEP_WAIT;
            STEP_EXEC: state_next = halt_now ? HALTED : STEP_WAIT;
            default:   state_next = state;
        endcase
    end

    // Stage controls: a taken branch squashes decode even over a stall, drain/HALT and load-use hold the front end
    always_comb begin
        bus.o_pc_enb      = adv && (bus.i_branch_taken || !stall);
        bus.o_if_id_enb   = adv && (bus.i_branch_taken || !stall);
        bus.o_if_id_flush = adv && bus.i_branch_taken;
        bus.o_id_ex_flush = adv && (bus.i_branch_taken || stall);
        bus.o_pipe_enb    = adv;
        bus.o_step_done   = step_done;
        bus.o_halted      = halted;
        bus.o_state       = state;
    end

    // State, drain counter and registered status flags
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            draining  <= 1'b0;
            drain_cnt <= '0;
            step_q    <= 1'b0;
            step_done <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            step_q    <= bus.i_step;
            step_done <= (state == STEP_EXEC);
            halted    <= halted || (state_next == HALTED);
            if (halt_start) begin
                draining  <= 1'b1;
                drain_cnt <= NB_DRAIN'(DRAIN_CYCLES - 1);
            end else if (adv && draining && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit: randomized and directed checks of the pipeline sequencer against a behavioural model
module tb_pipeline_control_unit;
    localparam int NB_ADDR = 5;
    localparam int DRAIN   = 3;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: phase 0 idle, 1 continuous, 2 step; m_left counts advances still owed before halting
    int m_phase;
    bit m_exec, m_prev_step, m_step_done, m_halted;
    int m_left;

    pipeline_control_unit_if #(.NB_ADDR(NB_ADDR)) bus ();

    pipeline_control_unit #(.NB_ADDR(NB_ADDR), .NB_DRAIN(2), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    function automatic void model_reset();
        m_phase = 0; m_exec = 0; m_prev_step = 0; m_step_done = 0; m_halted = 0; m_left = 0;
    endfunction

    function automatic bit m_adv();
        return !m_halted && (m_phase == 1 || (m_phase == 2 && m_exec));
    endfunction

    function automatic logic [9:0] expected();
        bit adv = m_adv();
        bit br  = bus.i_branch_taken;
        bit luh = bus.i_id_ex_mem_rd_enb && bus.i_id_ex_rt_addr != 0 &&
                  (bus.i_id_ex_rt_addr == bus.i_if_id_rs_addr || bus.i_id_ex_rt_addr == bus.i_if_id_rt_addr);
        bit stall = m_left > 0 || bus.i_halt_detected || luh;
        bit go = adv && (br || !stall);
        logic [2:0] st = m_halted ? 3'd4 : m_phase == 0 ? 3'd0 : m_phase == 1 ? 3'd1 : m_exec ? 3'd3 : 3'd2;
        return {go, go, adv && br, adv && (br || stall), adv, m_step_done, m_halted, st};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.o_pc_enb, bus.o_if_id_enb, bus.o_if_id_flush, bus.o_id_ex_flush, bus.o_pipe_enb,
                bus.o_step_done, bus.o_halted, bus.o_state};
    endfunction

    function automatic void model_clock();
        bit adv = m_adv();
        m_step_done = !m_halted && m_phase == 2 && m_exec;
        if (adv) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_halted = 1;
            end else if (bus.i_halt_detected && !bus.i_branch_taken) begin
                m_left = DRAIN;
            end
        end
        if (m_phase == 0) begin
            if (bus.i_start) m_phase = bus.i_mode_step ? 2 : 1;
        end else if (m_phase == 2) begin
            m_exec = !m_exec && bus.i_step && !m_prev_step;
        end
        m_prev_step = bus.i_step;
    endfunction

    task automatic advance();
        @(posedge i_clock);
        if (i_reset) model_reset(); else model_clock();
        #1;
    endtask

    task automatic clear_in();
        bus.i_start = 0; bus.i_mode_step = 0; bus.i_step = 0; bus.i_halt_detected = 0;
        bus.i_id_ex_mem_rd_enb = 0; bus.i_id_ex_rt_addr = '0; bus.i_if_id_rs_addr = '0;
        bus.i_if_id_rt_addr = '0; bus.i_branch_taken = 0;
    endtask

    task automatic rand_in(input int halt_pct);
        bus.i_start            = ($urandom_range(0, 9) == 0);
        bus.i_mode_step        = 1'($urandom_range(0, 1));
        bus.i_step             = ($urandom_range(0, 2) == 0);
        bus.i_halt_detected    = ($urandom_range(0, 99) < halt_pct);
        bus.i_id_ex_mem_rd_enb = 1'($urandom_range(0, 1));
        bus.i_id_ex_rt_addr    = NB_ADDR'($urandom_range(0, 3));
        bus.i_if_id_rs_addr    = NB_ADDR'($urandom_range(0, 3));
        bus.i_if_id_rt_addr    = NB_ADDR'($urandom_range(0, 3));
        bus.i_branch_taken     = ($urandom_range(0, 6) == 0);
    endtask

    task automatic do_reset();
        clear_in();
        i_reset = 1;
        model_reset();
        repeat (2) advance();
        i_reset = 0;
    endtask

    task automatic start_mode(input bit step_mode);
        clear_in();
        bus.i_start = 1;
        bus.i_mode_step = step_mode;
        advance();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        i_reset = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rand_in(50);
            @(negedge i_clock);
            n_checks++;
            if (observed() !== 10'd0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %b, expected %b", i, observed(), 10'd0);
            end
            advance();
        end
        i_reset = 0;
        for (int i = 0; i < 3; i++) begin
            rand_in(50);
            bus.i_start = 0;
            @(negedge i_clock);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL idle_frozen cycle %0d: got %b, expected %b", i, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_run_start();
        start_mode(0);
        @(negedge i_clock);
        n_checks++;
        if (observed() !== {5'b11001, 1'b0, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL run_start: got %b, expected %b", observed(), {5'b11001, 1'b0, 1'b0, 3'd1});
        end
        advance();
    endtask

    task automatic test_load_use();
        clear_in();
        bus.i_id_ex_mem_rd_enb = 1; bus.i_id_ex_rt_addr = 5; bus.i_if_id_rs_addr = 5; bus.i_if_id_rt_addr = 2;
        @(negedge i_clock);
        n_checks++;
        if ({bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_flush, bus.o_pipe_enb} !== 4'b0011) begin
            n_fail++;
            $display("FAIL luh_stall: got %b, expected 0011", {bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_flush, bus.o_pipe_enb});
        end
        advance();
        clear_in();
        @(negedge i_clock);
        n_checks++;
        if ({bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_flush} !== 3'b110) begin
            n_fail++;
            $display("FAIL luh_release: got %b, expected 110", {bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_flush});
        end
        advance();
        bus.i_id_ex_mem_rd_enb = 1; bus.i_id_ex_rt_addr = 0; bus.i_if_id_rs_addr = 0; bus.i_if_id_rt_addr = 0;
        @(negedge i_clock);
        n_checks++;
        if ({bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_flush} !== 3'b110) begin
            n_fail++;
            $display("FAIL luh_r0: got %b, expected 110", {bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_flush});
        end
        advance();
    endtask

    task automatic test_branch_over_luh();
        clear_in();
        bus.i_id_ex_mem_rd_enb = 1; bus.i_id_ex_rt_addr = 7; bus.i_if_id_rt_addr = 7; bus.i_branch_taken = 1;
        @(negedge i_clock);
        n_checks++;
        if ({bus.o_pc_enb, bus.o_if_id_enb, bus.o_if_id_flush, bus.o_id_ex_flush, bus.o_pipe_enb} !== 5'b11111) begin
            n_fail++;
            $display("FAIL branch_luh: got %b, expected 11111",
                     {bus.o_pc_enb, bus.o_if_id_enb, bus.o_if_id_flush, bus.o_id_ex_flush, bus.o_pipe_enb});
        end
        advance();
        clear_in();
    endtask

    task automatic test_random_run();
        for (int i = 0; i < 150; i++) begin
            rand_in(0);
            @(negedge i_clock);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL run_random cycle %0d: got %b, expected %b", i, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_halt();
        int  stalls = 0;
        bit  done = 0;
        clear_in();
        bus.i_halt_detected = 1;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge i_clock);
            if (bus.o_halted) begin
                done = 1;
            end else begin
                n_checks++;
                if (observed() !== expected()) begin
                    n_fail++;
                    $display("FAIL halt_drain cycle %0d: got %b, expected %b", i, observed(), expected());
                end
                if (!bus.o_pc_enb && bus.o_id_ex_flush && bus.o_pipe_enb) stalls++;
                advance();
            end
        end
        n_checks++;
        if (!done || bus.o_state !== 3'd4 || stalls != DRAIN + 1) begin
            n_fail++;
            $display("FAIL halt_reached: halted=%b state=%0d drain_cycles=%0d, expected halted=1 state=4 drain_cycles=%0d",
                     bus.o_halted, bus.o_state, stalls, DRAIN + 1);
        end
        clear_in();
        for (int i = 0; i < 3; i++) begin
            bus.i_start = 1;
            bus.i_mode_step = 1'(i);
            @(negedge i_clock);
            n_checks++;
            if (observed() !== {5'b00000, 1'b0, 1'b1, 3'd4}) begin
                n_fail++;
                $display("FAIL halt_sticky cycle %0d: got %b, expected %b", i, observed(), {5'b00000, 1'b0, 1'b1, 3'd4});
            end
            advance();
        end
    endtask

    task automatic test_step();
        int advances = 0;
        do_reset();
        start_mode(1);
        for (int c = 0; c < 30; c++) begin
            bus.i_step = (c == 10 || c == 20);
            @(negedge i_clock);
            n_checks++;
            if (observed() !== expected() || bus.o_pipe_enb !== (c == 11 || c == 21) || bus.o_step_done !== (c == 12 || c == 22)) begin
                n_fail++;
                $display("FAIL step_pulse cycle %0d: got %b, expected %b", c, observed(), expected());
            end
            advance();
        end
        for (int c = 0; c < 10; c++) begin
            bus.i_step = (c < 3);
            @(negedge i_clock);
            if (bus.o_pipe_enb) advances++;
            advance();
        end
        n_checks++;
        if (advances != 1) begin
            n_fail++;
            $display("FAIL step_held: got %0d advances, expected 1", advances);
        end
        clear_in();
    endtask

    task automatic test_random_step_halt();
        do_reset();
        start_mode(1);
        for (int i = 0; i < 300; i++) begin
            rand_in(4);
            @(negedge i_clock);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL step_random cycle %0d: got %b, expected %b", i, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_random_run_halt();
        do_reset();
        start_mode(0);
        for (int i = 0; i < 200; i++) begin
            rand_in(3);
            @(negedge i_clock);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL run_halt_random cycle %0d: got %b, expected %b", i, observed(), expected());
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_mode(0);
        bus.i_halt_detected = 1;
        repeat (2) advance();
        #1;
        i_reset = 1;
        #1;
        n_checks++;
        if (observed() !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected %b", observed(), 10'd0);
        end
        model_reset();
        clear_in();
        advance();
        i_reset = 0;
        @(negedge i_clock);
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL after_async_reset: got %b, expected %b", observed(), expected());
        end
        advance();
    endtask

    initial begin
        clear_in();
        model_reset();
        test_reset();
        test_run_start();
        test_load_use();
        test_branch_over_luh();
        test_random_run();
        test_halt();
        test_step();
        test_random_step_halt();
        test_random_run_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
